// File: rtl/reg_file_param.sv
// Parameterised register file with two registered read ports, write-first forwarding,
// and a one-entry-per-cycle clear sequencer that holds off reads and writes while running.
module reg_file_param #(
   parameter  int WIDTH    = 16,
   parameter  int DEPTH    = 8,
   parameter  int ZERO_REG = 0,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             rd_en,
   input  logic [AW-1:0]    read1,
   input  logic [AW-1:0]    read2,
   output logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] data2,
   output logic             data_valid,
   input  logic             reg_write,
   input  logic [AW-1:0]    write_reg,
   input  logic [WIDTH-1:0] write_data,
   input  logic             clear_req,
   output logic             busy
);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [WIDTH-1:0] data1_q, data1_d;
   logic [WIDTH-1:0] data2_q, data2_d;
   logic             valid_q, valid_d;

   logic             wr_ok;
   logic             rd_ok;
   logic [WIDTH-1:0] rd1_val;
   logic [WIDTH-1:0] rd2_val;

   // Addresses past DEPTH exist whenever DEPTH is not a power of two.
   function automatic logic in_range(input logic [AW-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   function automatic logic zero_slot(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // A clear request wins over a coincident write; the read on that edge still sees old data.
   assign wr_ok = reg_write && (state_q == IDLE) && !clear_req
                  && in_range(write_reg) && !zero_slot(write_reg);
   assign rd_ok = rd_en && (state_q == IDLE);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch can be inferred.
      rd1_val = '0;
      rd2_val = '0;
      if (in_range(read1) && !zero_slot(read1))
         rd1_val = (wr_ok && write_reg == read1) ? write_data : regs_q[read1];
      if (in_range(read2) && !zero_slot(read2))
         rd2_val = (wr_ok && write_reg == read2) ? write_data : regs_q[read2];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      regs_d  = regs_q;
      data1_d = data1_q;
      data2_d = data2_q;
      valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            regs_d[cnt_q] = '0;
            if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
            else                         cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (wr_ok) regs_d[write_reg] = write_data;

      if (rd_ok) begin
         valid_d = 1'b1;
         data1_d = rd1_val;
         data2_d = rd2_val;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data1_q <= '0;
         data2_q <= '0;
         valid_q <= 1'b0;
         // NOTE: the entries are plain flops, so resetting them is legal; reset must zero them.
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         valid_q <= valid_d;
         regs_q  <= regs_d;
      end
   end

   assign data1      = data1_q;
   assign data2      = data2_q;
   assign data_valid = valid_q;
   assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: default instance, a ZERO_REG twin sharing its inputs, and a 32x6 instance.
module tb_reg_file_param;

   logic        clock;
   logic        reset_n;

   logic        rd_en, reg_write, clear_req;
   logic [2:0]  read1, read2, write_reg;
   logic [15:0] write_data;
   logic [15:0] d1_a, d2_a, d1_z, d2_z;
   logic        dv_a, dv_z, busy_a, busy_z;

   logic        w_rd_en, w_reg_write, w_clear_req;
   logic [2:0]  w_read1, w_read2, w_write_reg;
   logic [31:0] w_write_data, w_d1, w_d2;
   logic        w_dv, w_busy;

   int cmps = 0;
   int errs = 0;

   reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut_a (
      .clock(clock), .reset_n(reset_n), .rd_en(rd_en), .read1(read1), .read2(read2),
      .data1(d1_a), .data2(d2_a), .data_valid(dv_a), .reg_write(reg_write),
      .write_reg(write_reg), .write_data(write_data), .clear_req(clear_req), .busy(busy_a));

   reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) dut_z (
      .clock(clock), .reset_n(reset_n), .rd_en(rd_en), .read1(read1), .read2(read2),
      .data1(d1_z), .data2(d2_z), .data_valid(dv_z), .reg_write(reg_write),
      .write_reg(write_reg), .write_data(write_data), .clear_req(clear_req), .busy(busy_z));

   reg_file_param #(.WIDTH(32), .DEPTH(6), .ZERO_REG(0)) dut_w (
      .clock(clock), .reset_n(reset_n), .rd_en(w_rd_en), .read1(w_read1), .read2(w_read2),
      .data1(w_d1), .data2(w_d2), .data_valid(w_dv), .reg_write(w_reg_write),
      .write_reg(w_write_reg), .write_data(w_write_data), .clear_req(w_clear_req), .busy(w_busy));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      reg_write = 1'b1; write_reg = a; write_data = d;
      tick();
      reg_write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
      rd_en = 1'b1; read1 = a1; read2 = a2;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic w_wr(input logic [2:0] a, input logic [31:0] d);
      w_reg_write = 1'b1; w_write_reg = a; w_write_data = d;
      tick();
      w_reg_write = 1'b0;
   endtask

   task automatic w_rd(input logic [2:0] a1, input logic [2:0] a2);
      w_rd_en = 1'b1; w_read1 = a1; w_read2 = a2;
      tick();
      w_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      cmps++;
      if ({d1_a, d2_a, dv_a, busy_a} !== 34'h0) begin
         errs++; $display("FAIL reset_a: got d1=%h d2=%h dv=%b busy=%b exp all 0", d1_a, d2_a, dv_a, busy_a);
      end
      cmps++;
      if ({d1_z, d2_z, dv_z, busy_z, w_d1, w_d2, w_dv, w_busy} !== 100'h0) begin
         errs++; $display("FAIL reset_zw: got z=%h/%h w=%h/%h dv=%b%b busy=%b%b exp all 0",
                          d1_z, d2_z, w_d1, w_d2, dv_z, w_dv, busy_z, w_busy);
      end
      repeat (2) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      tick();
      cmps++;
      if ({dv_a, busy_a} !== 2'b00) begin
         errs++; $display("FAIL after_reset: got dv=%b busy=%b exp 0 0", dv_a, busy_a);
      end
   endtask

   task automatic test_basic();
      wr(3'd3, 16'h1234);
      rd(3'd3, 3'd0);
      cmps++;
      if ({d1_a, d2_a, dv_a} !== {16'h1234, 16'h0000, 1'b1}) begin
         errs++; $display("FAIL basic_read: got d1=%h d2=%h dv=%b exp 1234 0000 1", d1_a, d2_a, dv_a);
      end
      tick();
      cmps++;
      if ({d1_a, d2_a, dv_a} !== {16'h1234, 16'h0000, 1'b0}) begin
         errs++; $display("FAIL basic_hold: got d1=%h d2=%h dv=%b exp 1234 0000 0", d1_a, d2_a, dv_a);
      end
   endtask

   task automatic test_forward();
      reg_write = 1'b1; write_reg = 3'd5; write_data = 16'hBEEF;
      rd_en = 1'b1; read1 = 3'd5; read2 = 3'd3;
      tick();
      reg_write = 1'b0; rd_en = 1'b0;
      cmps++;
      if ({d1_a, d2_a, dv_a} !== {16'hBEEF, 16'h1234, 1'b1}) begin
         errs++; $display("FAIL fwd_same_edge: got d1=%h d2=%h dv=%b exp beef 1234 1", d1_a, d2_a, dv_a);
      end
      rd(3'd5, 3'd5);
      cmps++;
      if ({d1_a, d2_a} !== {16'hBEEF, 16'hBEEF}) begin
         errs++; $display("FAIL fwd_stored: got d1=%h d2=%h exp beef beef", d1_a, d2_a);
      end
   endtask

   task automatic test_zero_reg();
      wr(3'd0, 16'hFFFF);
      rd(3'd0, 3'd3);
      cmps++;
      if ({d1_a, d1_z, d2_z} !== {16'hFFFF, 16'h0000, 16'h1234}) begin
         errs++; $display("FAIL zero_sep: got a.d1=%h z.d1=%h z.d2=%h exp ffff 0000 1234", d1_a, d1_z, d2_z);
      end
      reg_write = 1'b1; write_reg = 3'd0; write_data = 16'hAAAA;
      rd_en = 1'b1; read1 = 3'd0; read2 = 3'd5;
      tick();
      reg_write = 1'b0; rd_en = 1'b0;
      cmps++;
      if ({d1_a, d1_z, d2_z, dv_z} !== {16'hAAAA, 16'h0000, 16'hBEEF, 1'b1}) begin
         errs++; $display("FAIL zero_fwd: got a.d1=%h z.d1=%h z.d2=%h z.dv=%b exp aaaa 0000 beef 1",
                          d1_a, d1_z, d2_z, dv_z);
      end
   endtask

   task automatic test_clear();
      int busy_cnt_a;
      int busy_cnt_z;
      int iter;
      for (int i = 0; i < 8; i++) wr(3'(i), 16'h1100 + 16'(i));
      // Clear edge also carries a write (must drop) and a read (must see old data).
      clear_req = 1'b1; reg_write = 1'b1; write_reg = 3'd1; write_data = 16'h9999;
      rd_en = 1'b1; read1 = 3'd1; read2 = 3'd2;
      tick();
      cmps++;
      if ({d1_a, d2_a, dv_a, busy_a} !== {16'h1101, 16'h1102, 1'b1, 1'b1}) begin
         errs++; $display("FAIL clear_edge_read: got d1=%h d2=%h dv=%b busy=%b exp 1101 1102 1 1",
                          d1_a, d2_a, dv_a, busy_a);
      end
      busy_cnt_a = busy_a ? 1 : 0;
      busy_cnt_z = busy_z ? 1 : 0;
      write_reg = 3'd4; write_data = 16'h7777; read1 = 3'd4; read2 = 3'd4;
      iter = 0;
      while ((busy_a || busy_z) && iter < 20) begin
         tick();
         iter++;
         if (busy_a) busy_cnt_a++;
         if (busy_z) busy_cnt_z++;
         cmps++;
         if ({dv_a, dv_z} !== 2'b00) begin
            errs++; $display("FAIL busy_no_valid: cycle %0d got dv_a=%b dv_z=%b exp 0 0", iter, dv_a, dv_z);
         end
      end
      clear_req = 1'b0; reg_write = 1'b0; rd_en = 1'b0;
      cmps++;
      if (busy_cnt_a != 8 || busy_cnt_z != 8) begin
         errs++; $display("FAIL busy_len: got a=%0d z=%0d cycles exp 8", busy_cnt_a, busy_cnt_z);
      end
      cmps++;
      if (d1_a !== 16'h1101) begin
         errs++; $display("FAIL busy_hold: got d1=%h exp 1101", d1_a);
      end
      for (int i = 0; i < 4; i++) begin
         rd(3'(i), 3'(7 - i));
         cmps++;
         if ({d1_a, d2_a, d1_z, d2_z} !== 64'h0) begin
            errs++; $display("FAIL cleared_%0d: got a=%h/%h z=%h/%h exp 0", i, d1_a, d2_a, d1_z, d2_z);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      for (int i = 0; i < 8; i++) wr(3'(i), 16'h2200 + 16'(i));
      rd(3'd1, 3'd6);
      cmps++;
      if ({d1_a, d2_a} !== {16'h2201, 16'h2206}) begin
         errs++; $display("FAIL refill: got d1=%h d2=%h exp 2201 2206", d1_a, d2_a);
      end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (3) tick();
      #2 reset_n = 1'b0;
      #1;
      cmps++;
      if ({busy_a, busy_z, dv_a, d1_a, d2_a} !== 35'h0) begin
         errs++; $display("FAIL midclear_reset: got busy=%b%b dv=%b d1=%h d2=%h exp all 0",
                          busy_a, busy_z, dv_a, d1_a, d2_a);
      end
      #2 reset_n = 1'b1;
      tick();
      cmps++;
      if ({busy_a, busy_z} !== 2'b00) begin
         errs++; $display("FAIL post_reset_busy: got %b%b exp 00", busy_a, busy_z);
      end
      for (int i = 0; i < 4; i++) begin
         rd(3'(i + 4), 3'(i));
         cmps++;
         if ({d1_a, d2_a, d1_z, d2_z, dv_a} !== {64'h0, 1'b1}) begin
            errs++; $display("FAIL reset_cleared_%0d: got a=%h/%h z=%h/%h dv=%b exp 0 dv=1",
                             i, d1_a, d2_a, d1_z, d2_z, dv_a);
         end
      end
   endtask

   task automatic test_wide();
      w_wr(3'd5, 32'hDEADBEEF);
      w_wr(3'd7, 32'h00000001);
      w_wr(3'd4, 32'h12345678);
      w_rd(3'd5, 3'd7);
      cmps++;
      if ({w_d1, w_d2, w_dv} !== {32'hDEADBEEF, 32'h0, 1'b1}) begin
         errs++; $display("FAIL wide_read: got d1=%h d2=%h dv=%b exp deadbeef 00000000 1", w_d1, w_d2, w_dv);
      end
      w_reg_write = 1'b1; w_write_reg = 3'd7; w_write_data = 32'hCAFEF00D;
      w_rd_en = 1'b1; w_read1 = 3'd7; w_read2 = 3'd4;
      tick();
      w_reg_write = 1'b0; w_rd_en = 1'b0;
      cmps++;
      if ({w_d1, w_d2} !== {32'h0, 32'h12345678}) begin
         errs++; $display("FAIL wide_oob_fwd: got d1=%h d2=%h exp 00000000 12345678", w_d1, w_d2);
      end
      w_rd(3'd6, 3'd0);
      cmps++;
      if ({w_d1, w_d2} !== 64'h0) begin
         errs++; $display("FAIL wide_oob6: got d1=%h d2=%h exp 0 0", w_d1, w_d2);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      rd_en = 1'b0; reg_write = 1'b0; clear_req = 1'b0;
      read1 = '0; read2 = '0; write_reg = '0; write_data = '0;
      w_rd_en = 1'b0; w_reg_write = 1'b0; w_clear_req = 1'b0;
      w_read1 = '0; w_read2 = '0; w_write_reg = '0; w_write_data = '0;
      test_reset();
      test_basic();
      test_forward();
      test_zero_reg();
      test_clear();
      test_reset_mid_clear();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 ns, exp finish");
      $fatal(1, "timeout");
   end

endmodule
